// File: rtl/bus_arb_pkg.sv
// ============================================================================
// Module  : bus_arb_pkg
// Brief   : State encoding shared by the 8088 bus hold arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLD_REQ = 3'd1,
        GRANT    = 3'd2,
        GAP      = 3'd3,
        RELEASE  = 3'd4
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module  : rr_priority_pick
// Brief   : Combinational round-robin pick: lowest requester at or above ptr,
//           otherwise the lowest requester overall.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       valid
);

    localparam int PTR_W = $clog2(NUM_REQ);

    // Descending scans so the last hit is the lowest index; the ptr-qualified
    // pass overrides the wrap-around choice whenever it finds a requester.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = i[PTR_W-1:0];
                valid = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                idx = i[PTR_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_hold_arbiter.sv
// ============================================================================
// Module  : bus_hold_arbiter
// Brief   : Requests the 8088 bus via hold/hlda and shares it round-robin
//           among DMA/refresh masters with bounded contended tenures.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_hold_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 8,
    parameter int HLDA_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               hold,
    input  logic               hlda,
    output logic               aen,
    output logic               fault
);

    import bus_arb_pkg::*;

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(MAX_BURST);
    localparam int TO_W    = $clog2(HLDA_TIMEOUT);

    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(NUM_REQ - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(HLDA_TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] ONE        = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t           state;
    logic [PTR_W-1:0]     owner;
    logic [PTR_W-1:0]     ptr;
    logic [BURST_W-1:0]   burst_cnt;
    logic [TO_W-1:0]      to_cnt;

    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [PTR_W-1:0]     pick_next;
    logic [NUM_REQ-1:0]   pick_mask;
    logic [NUM_REQ-1:0]   owner_mask;
    logic                 others_req;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign pick_next  = (pick_idx == PTR_LAST) ? '0 : pick_idx + PTR_W'(1);
    assign pick_mask  = ONE << pick_idx;
    assign owner_mask = ONE << owner;
    assign others_req = |(req & ~owner_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            to_cnt    <= '0;
            grant     <= '0;
            hold      <= 1'b0;
            aen       <= 1'b0;
            fault     <= 1'b0;
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state  <= HOLD_REQ;
                        hold   <= 1'b1;
                        to_cnt <= '0;
                    end
                end
                HOLD_REQ: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (hlda && pick_valid) begin
                        state     <= GRANT;
                        owner     <= pick_idx;
                        ptr       <= pick_next;
                        burst_cnt <= '0;
                        grant     <= pick_mask;
                        aen       <= 1'b1;
                    end else if (hlda) begin
                        state <= RELEASE;
                        hold  <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        state <= RELEASE;
                        hold  <= 1'b0;
                        fault <= 1'b1;
                    end
                end
                GRANT: begin
                    if (burst_cnt != BURST_LAST) begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                    end
                    // CPU took the bus back underneath us: abandon the tenure.
                    if (!hlda) begin
                        state <= RELEASE;
                        grant <= '0;
                        hold  <= 1'b0;
                        aen   <= 1'b0;
                        fault <= 1'b1;
                    end else if (!req[owner] ||
                                 ((burst_cnt == BURST_LAST) && others_req)) begin
                        state <= GAP;
                        grant <= '0;
                    end
                end
                GAP: begin
                    if (pick_valid) begin
                        state     <= GRANT;
                        owner     <= pick_idx;
                        ptr       <= pick_next;
                        burst_cnt <= '0;
                        grant     <= pick_mask;
                    end else begin
                        state <= RELEASE;
                        hold  <= 1'b0;
                        aen   <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!hlda) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    hold  <= 1'b0;
                    aen   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_hold_arbiter.sv
// ============================================================================
// Module  : tb_bus_hold_arbiter
// Brief   : Scenario bench for bus_hold_arbiter with a cycle expectation queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_hold_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       hlda = 1'b0;
    logic [3:0] grant;
    logic       hold;
    logic       aen;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] req;
        logic       hlda;
        logic [6:0] exp;
    } step_t;

    step_t      stim[$];
    logic [6:0] sb[$];
    logic [6:0] got;
    logic [6:0] want;

    bus_hold_arbiter #(
        .NUM_REQ      (4),
        .MAX_BURST    (8),
        .HLDA_TIMEOUT (64)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant),
        .hold  (hold),
        .hlda  (hlda),
        .aen   (aen),
        .fault (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected output vector {grant, hold, aen, fault}
    function automatic logic [6:0] o(input logic [3:0] g, input logic h,
                                     input logic a, input logic f);
        return {g, h, a, f};
    endfunction

    function automatic void add(input logic [3:0] r, input logic h,
                                input logic [6:0] e, input int n);
        for (int k = 0; k < n; k++) begin
            stim.push_back('{req: r, hlda: h, exp: e});
        end
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        hlda = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        stim.delete();
        sb.delete();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b1111;
        hlda = 1'b1;
        @(posedge clk); #1;
        got = {grant, hold, aen, fault};
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=%b", got, 7'b0);
        end
        req  = '0;
        hlda = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        got = {grant, hold, aen, fault};
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b", got, 7'b0);
        end
    endtask

    task automatic test_single();
        do_reset();
        add(4'b0001, 1'b0, o(4'b0000, 1, 0, 0), 3);
        add(4'b0001, 1'b1, o(4'b0001, 1, 1, 0), 12);
        add(4'b0000, 1'b1, o(4'b0000, 1, 1, 0), 1);
        add(4'b0000, 1'b1, o(4'b0000, 0, 0, 0), 2);
        add(4'b0001, 1'b0, o(4'b0000, 0, 0, 0), 1);
        add(4'b0000, 1'b0, o(4'b0000, 0, 0, 0), 2);
        foreach (stim[i]) begin
            req  = stim[i].req;
            hlda = stim[i].hlda;
            sb.push_back(stim[i].exp);
            @(posedge clk); #1;
            got  = {grant, hold, aen, fault};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL single step=%0d got=%b exp=%b", i, got, want);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        add(4'b1011, 1'b0, o(4'b0000, 1, 0, 0), 1);
        add(4'b1011, 1'b1, o(4'b0001, 1, 1, 0), 8);
        add(4'b1011, 1'b1, o(4'b0000, 1, 1, 0), 1);
        add(4'b1011, 1'b1, o(4'b0010, 1, 1, 0), 8);
        add(4'b1011, 1'b1, o(4'b0000, 1, 1, 0), 1);
        add(4'b1011, 1'b1, o(4'b1000, 1, 1, 0), 8);
        add(4'b1011, 1'b1, o(4'b0000, 1, 1, 0), 1);
        add(4'b1011, 1'b1, o(4'b0001, 1, 1, 0), 3);
        foreach (stim[i]) begin
            req  = stim[i].req;
            hlda = stim[i].hlda;
            sb.push_back(stim[i].exp);
            @(posedge clk); #1;
            got  = {grant, hold, aen, fault};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL round_robin step=%0d got=%b exp=%b", i, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        add(4'b0001, 1'b0, o(4'b0000, 1, 0, 0), 64);
        add(4'b0001, 1'b0, o(4'b0000, 0, 0, 1), 1);
        add(4'b0001, 1'b0, o(4'b0000, 0, 0, 0), 1);
        add(4'b0001, 1'b0, o(4'b0000, 1, 0, 0), 2);
        add(4'b0001, 1'b1, o(4'b0001, 1, 1, 0), 2);
        foreach (stim[i]) begin
            req  = stim[i].req;
            hlda = stim[i].hlda;
            sb.push_back(stim[i].exp);
            @(posedge clk); #1;
            got  = {grant, hold, aen, fault};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL timeout step=%0d got=%b exp=%b", i, got, want);
            end
        end
    endtask

    task automatic test_hlda_drop();
        do_reset();
        add(4'b0010, 1'b0, o(4'b0000, 1, 0, 0), 1);
        add(4'b0010, 1'b1, o(4'b0010, 1, 1, 0), 4);
        add(4'b0010, 1'b0, o(4'b0000, 0, 0, 1), 1);
        add(4'b0010, 1'b0, o(4'b0000, 0, 0, 0), 1);
        add(4'b0010, 1'b0, o(4'b0000, 1, 0, 0), 1);
        add(4'b0010, 1'b1, o(4'b0010, 1, 1, 0), 2);
        foreach (stim[i]) begin
            req  = stim[i].req;
            hlda = stim[i].hlda;
            sb.push_back(stim[i].exp);
            @(posedge clk); #1;
            got  = {grant, hold, aen, fault};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL hlda_drop step=%0d got=%b exp=%b", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_tenure();
        do_reset();
        // Master 1 owns the bus, leaving ptr at 2 before reset hits.
        add(4'b0010, 1'b0, o(4'b0000, 1, 0, 0), 1);
        add(4'b0010, 1'b1, o(4'b0010, 1, 1, 0), 3);
        // Master 3 would win from ptr=2, so winning master 1 proves ptr=0.
        add(4'b1010, 1'b0, o(4'b0000, 1, 0, 0), 1);
        add(4'b1010, 1'b1, o(4'b0010, 1, 1, 0), 2);
        foreach (stim[i]) begin
            req  = stim[i].req;
            hlda = stim[i].hlda;
            sb.push_back(stim[i].exp);
            @(posedge clk); #1;
            got  = {grant, hold, aen, fault};
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid step=%0d got=%b exp=%b", i, got, want);
            end
            if (i == 3) begin
                #3;
                rst = 1'b1;
                #1;
                got = {grant, hold, aen, fault};
                checks++;
                if (got !== 7'b0) begin
                    failures++;
                    $display("FAIL reset_async got=%b exp=%b", got, 7'b0);
                end
                hlda = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_hlda_drop();
        test_reset_mid_tenure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
